proc_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the multi-cycle processor control FSM.
- Owns the program counter and runs a req/ack handshake to instruction memory.
- Holds the fetched 16-bit instruction stable on instr for the Decode, execute, memory and writeback cycles.
- Applies branch/jump redirects decided in Decode (opcodes 7 and 6).

---
 rtl/proc_fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_proc_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the req/ack handshake to imem and applies redirects.
// Optional macro FETCH_TIMEOUT_EN enables an abort with fetch_err after TIMEOUT_CYC unacknowledged cycles.
module proc_fetch_unit #(
    parameter int              PC_W        = 8,
    parameter logic [PC_W-1:0] RESET_PC    = {PC_W{1'b0}},
    parameter int              TIMEOUT_CYC = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_start_i,
    input  logic            redirect_en_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [15:0]     imem_rdata_i,
    output logic [15:0]     instr_o,
    output logic            instr_valid_o,
    output logic [PC_W-1:0] pc_o,
    output logic            busy_o,
    output logic            fetch_err_o
);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            imem_req_q, imem_req_d;
    logic [PC_W-1:0] imem_addr_q, imem_addr_d;
    logic            pend_q, pend_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    logic [PC_W-1:0] redir_tgt_s;
    logic            redir_any_s;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fetch_err_q, fetch_err_d;
`endif

    // A redirect seen in the completing cycle is the newest target and wins over an older pending one.
    assign redir_any_s = redirect_en_i | pend_q;
    assign redir_tgt_s = redirect_en_i ? redirect_pc_i : pend_pc_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 16'h0000;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= {PC_W{1'b0}};
            pend_q        <= 1'b0;
            pend_pc_q     <= {PC_W{1'b0}};
`ifdef FETCH_TIMEOUT_EN
            cnt_q         <= {CNT_W{1'b0}};
            fetch_err_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            pend_q        <= pend_d;
            pend_pc_q     <= pend_pc_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q         <= cnt_d;
            fetch_err_q   <= fetch_err_d;
`endif
        end
    end

    // Next-state and handshake logic.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        pend_d        = pend_q;
        pend_pc_d     = pend_pc_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d         = cnt_q;
        fetch_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (redirect_en_i) begin
                    pc_d = redirect_pc_i;
                end else begin
                    pc_d = pc_q;
                end
                if (fetch_start_i) begin
                    state_d     = REQ;
                    imem_req_d  = 1'b1;
                    imem_addr_d = redirect_en_i ? redirect_pc_i : pc_q;
                    pend_d      = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d       = {CNT_W{1'b0}};
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (redirect_en_i) begin
                    pend_d    = 1'b1;
                    pend_pc_d = redirect_pc_i;
                end else begin
                    pend_d    = pend_q;
                end
                if (imem_ack_i) begin
                    state_d       = IDLE;
                    imem_req_d    = 1'b0;
                    instr_d       = imem_rdata_i;
                    instr_valid_d = 1'b1;
                    pend_d        = 1'b0;
                    pc_d          = redir_any_s ? redir_tgt_s : pc_q + PC_ONE;
`ifdef FETCH_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    // Abort delivers a NOP and leaves pc on the failed address so the next fetch retries it.
                    state_d       = IDLE;
                    imem_req_d    = 1'b0;
                    instr_d       = 16'h0000;
                    instr_valid_d = 1'b1;
                    fetch_err_d   = 1'b1;
                    pend_d        = 1'b0;
                    pc_d          = redir_any_s ? redir_tgt_s : pc_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
`else
                end else begin
                    state_d = REQ;
`endif
                end
            end
            default: begin
                state_d    = IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    assign imem_req_o    = imem_req_q;
    assign imem_addr_o   = imem_addr_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = instr_valid_q;
    assign pc_o          = pc_q;
    assign busy_o        = (state_q == REQ);
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err_o   = fetch_err_q;
`else
    assign fetch_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_proc_fetch_unit.sv
// Self-checking bench for proc_fetch_unit: directed vector table, hand sequences and a randomized reference model.
module tb_proc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start, redirect_en, imem_ack;
    logic [7:0]  redirect_pc;
    logic [15:0] imem_rdata;
    logic        imem_req, instr_valid, busy, fetch_err;
    logic [7:0]  imem_addr, pc;
    logic [15:0] instr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    proc_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_start_i (fetch_start),
        .redirect_en_i (redirect_en),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .pc_o          (pc),
        .busy_o        (busy),
        .fetch_err_o   (fetch_err)
    );

    typedef struct {
        logic        fs;
        logic        re;
        logic [7:0]  rpc;
        logic        ack;
        logic [15:0] rdata;
        logic        e_req;
        logic [7:0]  e_addr;
        logic [15:0] e_instr;
        logic        e_valid;
        logic [7:0]  e_pc;
        logic        e_busy;
    } vec_t;

    vec_t vt [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fs, input logic re, input logic [7:0] rpc,
                         input logic ack, input logic [15:0] rd);
        fetch_start = fs;
        redirect_en = re;
        redirect_pc = rpc;
        imem_ack    = ack;
        imem_rdata  = rd;
    endtask

    // One clock edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state.
    logic [7:0]  m_pc;
    logic [15:0] m_instr;
    logic [7:0]  m_addr;
    logic        m_pend;
    logic [7:0]  m_tgt;
    logic [15:0] rd;
    logic [7:0]  rp;
    logic        r_re;
    int          n_req;

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
        step();
        step();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_addr", imem_addr, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", fetch_err, 1'b0);
        rst = 1'b0;

        //          fs    re    rpc    ack   rdata     req   addr   instr     vld   pc     busy
        vt[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1};
        vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h1A4B, 1'b0, 8'h00, 16'h1A4B, 1'b1, 8'h01, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h1A4B, 1'b0, 8'h01, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 8'h40, 1'b0, 16'h0000, 1'b1, 8'h40, 16'h1A4B, 1'b0, 8'h40, 1'b1};
        vt[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h2222, 1'b0, 8'h40, 16'h2222, 1'b1, 8'h41, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 16'h0000, 1'b0, 8'h40, 16'h2222, 1'b0, 8'hFF, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'hFF, 16'h2222, 1'b0, 8'hFF, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 16'hDEAD, 1'b1, 8'hFF, 16'h2222, 1'b0, 8'hFF, 1'b1};
        vt[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'hFF, 16'h2222, 1'b0, 8'hFF, 1'b1};
        vt[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'hFF, 16'h2222, 1'b0, 8'hFF, 1'b1};
        vt[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h7200, 1'b0, 8'hFF, 16'h7200, 1'b1, 8'h00, 1'b0};
        vt[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hBEEF, 1'b0, 8'hFF, 16'h7200, 1'b0, 8'h00, 1'b0};
        vt[13] = '{1'b0, 1'b1, 8'h05, 1'b0, 16'h0000, 1'b0, 8'hFF, 16'h7200, 1'b0, 8'h05, 1'b0};
        vt[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h05, 16'h7200, 1'b0, 8'h05, 1'b1};
        vt[15] = '{1'b0, 1'b1, 8'h10, 1'b0, 16'h0000, 1'b1, 8'h05, 16'h7200, 1'b0, 8'h05, 1'b1};
        vt[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h3333, 1'b0, 8'h05, 16'h3333, 1'b1, 8'h10, 1'b0};
        vt[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h05, 16'h3333, 1'b0, 8'h10, 1'b0};

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].fs, vt[i].re, vt[i].rpc, vt[i].ack, vt[i].rdata);
            step();
            chk($sformatf("vec%0d_req", i), imem_req, vt[i].e_req);
            chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].e_addr);
            chk($sformatf("vec%0d_instr", i), instr, vt[i].e_instr);
            chk($sformatf("vec%0d_valid", i), instr_valid, vt[i].e_valid);
            chk($sformatf("vec%0d_pc", i), pc, vt[i].e_pc);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
            chk($sformatf("vec%0d_err", i), fetch_err, 1'b0);
        end

        // Reset during REQ, then a late ack.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
        step();
        chk("rstreq_pre_req", imem_req, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstreq_req", imem_req, 1'b0);
        chk("rstreq_pc", pc, 8'h00);
        chk("rstreq_instr", instr, 16'h0000);
        chk("rstreq_valid", instr_valid, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 16'h5A5A);
        step();
        chk("late_ack_valid", instr_valid, 1'b0);
        chk("late_ack_instr", instr, 16'h0000);
        chk("late_ack_pc", pc, 8'h00);
        chk("late_ack_req", imem_req, 1'b0);

        // Long wait with no ack: timeout abort or indefinite hold.
        drive(1'b0, 1'b1, 8'h22, 1'b0, 16'h0000);
        step();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
        n_req = 0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req !== 1'b1) break;
            chk($sformatf("wait%0d_addr", i), imem_addr, 8'h22);
            chk($sformatf("wait%0d_err", i), fetch_err, 1'b0);
            n_req++;
            if (i < 39) step();
        end
`ifdef FETCH_TIMEOUT_EN
        chk("to_req_cycles", n_req, 15);
        chk("to_err", fetch_err, 1'b1);
        chk("to_valid", instr_valid, 1'b1);
        chk("to_instr", instr, 16'h0000);
        chk("to_pc", pc, 8'h22);
        step();
        chk("to_err_drop", fetch_err, 1'b0);
        chk("to_valid_drop", instr_valid, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000);
        step();
        chk("retry_addr", imem_addr, 8'h22);
        chk("retry_req", imem_req, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
`else
        chk("hold_req_cycles", n_req, 40);
        chk("hold_busy", busy, 1'b1);
`endif
        drive(1'b0, 1'b0, 8'h00, 1'b1, 16'h6161);
        step();
        chk("wait_done_instr", instr, 16'h6161);
        chk("wait_done_valid", instr_valid, 1'b1);
        chk("wait_done_pc", pc, 8'h23);

        // Randomized transactions against a behavioural model.
        m_pc    = 8'h23;
        m_instr = 16'h6161;
        for (int t = 0; t < 60; t++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                r_re = 1'($urandom_range(0, 1));
                rp   = 8'($urandom_range(0, 255));
                drive(1'b0, r_re, rp, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)));
                if (r_re) m_pc = rp;
                step();
                chk("rnd_idle_pc", pc, m_pc);
                chk("rnd_idle_instr", instr, m_instr);
                chk("rnd_idle_valid", instr_valid, 1'b0);
                chk("rnd_idle_req", imem_req, 1'b0);
            end
            r_re = ($urandom_range(0, 3) == 0);
            rp   = 8'($urandom_range(0, 255));
            drive(1'b1, r_re, rp, 1'b0, 16'h0000);
            m_addr = r_re ? rp : m_pc;
            m_pend = 1'b0;
            step();
            chk("rnd_start_req", imem_req, 1'b1);
            chk("rnd_start_addr", imem_addr, m_addr);
            chk("rnd_start_valid", instr_valid, 1'b0);
            for (int w = 0; w < int'($urandom_range(0, 6)); w++) begin
                r_re = ($urandom_range(0, 3) == 0);
                rp   = 8'($urandom_range(0, 255));
                drive(1'($urandom_range(0, 1)), r_re, rp, 1'b0, 16'($urandom_range(0, 65535)));
                if (r_re) begin
                    m_pend = 1'b1;
                    m_tgt  = rp;
                end
                step();
                chk("rnd_wait_req", imem_req, 1'b1);
                chk("rnd_wait_addr", imem_addr, m_addr);
                chk("rnd_wait_busy", busy, 1'b1);
            end
            r_re = ($urandom_range(0, 3) == 0);
            rp   = 8'($urandom_range(0, 255));
            rd   = 16'($urandom_range(0, 65535));
            drive(1'b0, r_re, rp, 1'b1, rd);
            if (r_re) begin
                m_pend = 1'b1;
                m_tgt  = rp;
            end
            m_pc    = m_pend ? m_tgt : 8'((int'(m_addr) + 1) % 256);
            m_instr = rd;
            step();
            chk("rnd_ack_valid", instr_valid, 1'b1);
            chk("rnd_ack_instr", instr, m_instr);
            chk("rnd_ack_pc", pc, m_pc);
            chk("rnd_ack_req", imem_req, 1'b0);
            drive(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
